// File: rtl/apb_master.sv
// APB4 requester: turns a valid/ready command stream into APB SETUP/ACCESS transfers, one response per command.
// Latency: command accepted in cycle N -> SETUP N+1, ACCESS N+2, rsp_valid N+3 plus one cycle per wait state.
// Backpressure: one transfer in flight; cmd_ready is low until the response has been handed off.
module apb_master #(
  parameter int AWIDTH  = 16,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AWIDTH-1:0]     cmd_addr,
  input  logic [DWIDTH-1:0]     cmd_wdata,
  input  logic [DWIDTH/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DWIDTH-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [AWIDTH-1:0]     paddr,
  output logic [DWIDTH-1:0]     pwdata,
  output logic [DWIDTH/8-1:0]   pstrb,
  input  logic                  pready,
  input  logic [DWIDTH-1:0]     prdata,
  input  logic                  pslverr
);

  localparam int SWIDTH = DWIDTH / 8;
  // Counter must hold TIMEOUT itself; a disabled timeout still keeps a 1-bit counter.
  localparam int CWIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CWIDTH-1:0] CNT_LIMIT = CWIDTH'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CWIDTH-1:0] wait_cnt;
  logic              accept;
  logic              timed_out;

  assign cmd_ready = (state == IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  // Abort only when the completer is still stalling; a pready in the limit cycle completes normally.
  assign timed_out = (TIMEOUT > 0) && !pready && (wait_cnt == CNT_LIMIT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timed_out) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered APB outputs, wait counter and response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            // Reads put nothing on the write lanes.
            pwdata  <= cmd_write ? cmd_wdata : '0;
            pstrb   <= cmd_write ? cmd_strb  : SWIDTH'(0);
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (pready) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (timed_out) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CWIDTH'(1);
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
